uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one UART transmitter; legal range 2..8.
REQ-002 Parameter BITLEN, default 8: byte width per requester.
REQ-003 Parameter TIMEOUT, default 16: clock cycles allowed for tx_busy to rise after a byte is issued.
REQ-004 clk  input  1  the block's only clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req_valid  input  NUM_REQ  per-requester request; the requester holds it high, with req_data stable, until acknowledged.
REQ-007 req_data  input  NUM_REQ*BITLEN  packed bytes; requester i occupies bits [i*BITLEN +: BITLEN].
REQ-008 req_ack  output  NUM_REQ  one-hot, one-cycle pulse; the byte of that requester has been captured.
REQ-009 grant  output  NUM_REQ  one-hot owner of the transmitter; all-zero when idle.
REQ-010 tx_data  output  BITLEN  byte presented to the transmitter.
REQ-011 tx_data_ready  output  1  one-cycle start pulse to the transmitter.
REQ-012 tx_busy  input  1  transmitter busy flag, registered, high from the cycle after tx_data_ready until the stop bit completes.
REQ-013 err_timeout  output  1  one-cycle pulse when tx_busy fails to rise within TIMEOUT cycles.

Function
REQ-014 FSM states SHALL be IDLE, WAIT_BUSY and WAIT_DONE; any unused encoding SHALL return to IDLE.
REQ-015 IDLE: if any req_valid is set and tx_busy=0, SHALL select requester by round-robin from pointer ptr (lowest index at or above ptr, wrapping), then at the clock edge register tx_data<=selected byte, tx_data_ready<=1, req_ack<=onehot(sel), grant<=onehot(sel), ptr<=(sel+1) mod NUM_REQ, state<=WAIT_BUSY.
REQ-016 IDLE with tx_busy=1 SHALL issue nothing, regardless of requests.
REQ-017 tx_data_ready and req_ack SHALL each be high for exactly one cycle per grant, in the first cycle of WAIT_BUSY.
REQ-018 tx_data SHALL stay stable from issue until return to IDLE; the transmitter samples it late in its start bit.
REQ-019 WAIT_BUSY: tx_busy=1 -> WAIT_DONE, timeout counter cleared; otherwise the counter increments, and at count==TIMEOUT-1 err_timeout pulses, grant clears, and state returns to IDLE.
REQ-020 WAIT_DONE: tx_busy=0 -> IDLE with grant cleared; no timeout applies in this state.
REQ-021 Requests SHALL be ignored outside IDLE; req_valid changes while not idle have no effect.
REQ-022 Back-to-back throughput: a new grant SHALL be possible in the first IDLE cycle after tx_busy falls (one idle cycle between transfers minimum).
REQ-023 A requester that drops req_valid before acknowledgement SHALL simply not be selected; no state is kept per requester.
REQ-024 ptr SHALL not advance on cycles without a grant; a timeout still leaves ptr advanced past the timed-out requester.
REQ-025 Timeout counter width SHALL be $clog2(TIMEOUT)+1 bits; no wrap before TIMEOUT-1 is reached.

Reset
REQ-026 With rst=1 at a clock edge: state=IDLE, ptr=0, timeout counter=0, grant=0, req_ack=0, tx_data=0, tx_data_ready=0, err_timeout=0.
REQ-027 Reset asserted mid-transfer SHALL abort immediately to the reset state; the transmitter is not signalled and finishes or resets independently.
REQ-028 First grant after reset SHALL favour requester 0 when several are valid.

Verification
REQ-029 Single request: req_valid=0001, req_data[7:0]=0x55 -> next cycle tx_data=0x55, tx_data_ready=1, req_ack=0001, grant=0001; grant clears one cycle after tx_busy falls.
REQ-030 All four valid continuously with bytes 0xA0..0xA3 -> transmitted order 0xA0,0xA1,0xA2,0xA3,0xA0; each req_ack bit pulses once per round.
REQ-031 Fairness wrap: after serving requester 3, valid=1001 -> requester 0 granted next, then 3.
REQ-032 Busy-stuck-low model, TIMEOUT=16 -> err_timeout pulses exactly 16 cycles after tx_data_ready, grant=0, ptr advanced, next request served normally.
REQ-033 tx_busy=1 at IDLE entry with valid=0010 -> no grant until tx_busy=0, then grant=0010 next edge.
REQ-034 rst=1 during WAIT_DONE -> all outputs zero next cycle; with valid=0110 after release, requester 1 is granted first.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Bundles the requester side and transmitter side of the arbiter.
//   Parameters: NUM_REQ requesters, BITLEN bits per byte.
//   Signals:
//     req_valid     requester -> arbiter, one bit per requester
//     req_data      requester -> arbiter, byte i at [i*BITLEN +: BITLEN]
//     req_ack       arbiter -> requester, one-hot single-cycle capture pulse
//     grant         arbiter -> requester, one-hot transmitter owner, 0 when idle
//     tx_data       arbiter -> transmitter, byte being sent
//     tx_data_ready arbiter -> transmitter, single-cycle start pulse
//     tx_busy       transmitter -> arbiter, registered busy flag
//     err_timeout   arbiter -> system, single-cycle timeout pulse
//     state_dbg     arbiter FSM state, for observation only
//
// Handshake: a requester raises req_valid[i] with req_data stable and keeps
// both unchanged until it sees req_ack[i] high for one cycle; the byte is
// captured on that edge and the requester may then drop or reuse the lane.
// The arbiter starts the transmitter with a one-cycle tx_data_ready pulse;
// the transmitter answers with tx_busy from the next cycle until it is done.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int BITLEN  = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*BITLEN-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ack;
    logic [NUM_REQ-1:0]        grant;
    logic [BITLEN-1:0]         tx_data;
    logic                      tx_data_ready;
    logic                      tx_busy;
    logic                      err_timeout;
    logic [1:0]                state_dbg;

    // Environment side: requesters plus transmitter.
    modport master (
        output req_valid, req_data, tx_busy,
        input  req_ack, grant, tx_data, tx_data_ready, err_timeout, state_dbg
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_data, tx_busy,
        output req_ack, grant, tx_data, tx_data_ready, err_timeout, state_dbg
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
//   A byte is issued only from IDLE while the transmitter is not busy; the
//   arbiter then waits for tx_busy to rise (bounded by TIMEOUT cycles) and to
//   fall again before it accepts the next request.
//   Parameters: NUM_REQ (2..8), BITLEN, TIMEOUT.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  uart_tx_arbiter_if.slave (requests, grant/ack, transmitter link)
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int BITLEN  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_arbiter_if.slave     bus
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t               state;
    logic [PTR_W-1:0]     ptr;
    logic [CNT_W-1:0]     cnt;
    logic [NUM_REQ-1:0]   grant_q;
    logic [NUM_REQ-1:0]   req_ack_q;
    logic [BITLEN-1:0]    tx_data_q;
    logic                 tx_data_ready_q;
    logic                 err_timeout_q;

    // Round-robin pick: the lowest valid index at or above ptr wins; if none
    // exists, the lowest valid index overall wins (the wrap case). Scanning
    // downward lets the last hit in each class be the lowest index.
    logic                 hi_any;
    logic                 lo_any;
    logic [PTR_W-1:0]     hi_idx;
    logic [PTR_W-1:0]     lo_idx;
    logic                 sel_found;
    logic [PTR_W-1:0]     sel_idx;
    logic [PTR_W-1:0]     ptr_next;
    logic [NUM_REQ-1:0]   sel_onehot;
    logic [BITLEN-1:0]    sel_byte;

    always_comb begin
        hi_any = 1'b0;
        lo_any = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (bus.req_valid[j]) begin
                lo_any = 1'b1;
                lo_idx = PTR_W'(j);
                if (PTR_W'(j) >= ptr) begin
                    hi_any = 1'b1;
                    hi_idx = PTR_W'(j);
                end
            end
        end
    end

    assign sel_found  = lo_any;
    assign sel_idx    = hi_any ? hi_idx : lo_idx;
    assign ptr_next   = (sel_idx == PTR_LAST) ? '0 : sel_idx + 1'b1;
    assign sel_onehot = ONE_HOT0 << sel_idx;

    always_comb begin
        sel_byte = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (sel_idx == PTR_W'(j)) begin
                sel_byte = bus.req_data[j*BITLEN +: BITLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            ptr             <= '0;
            cnt             <= '0;
            grant_q         <= '0;
            req_ack_q       <= '0;
            tx_data_q       <= '0;
            tx_data_ready_q <= 1'b0;
            err_timeout_q   <= 1'b0;
        end else begin
            // Pulse outputs default low; only the issuing edge or the
            // timeout edge raises them for a single cycle.
            tx_data_ready_q <= 1'b0;
            req_ack_q       <= '0;
            err_timeout_q   <= 1'b0;

            case (state)
                IDLE: begin
                    if (sel_found && !bus.tx_busy) begin
                        tx_data_q       <= sel_byte;
                        tx_data_ready_q <= 1'b1;
                        req_ack_q       <= sel_onehot;
                        grant_q         <= sel_onehot;
                        ptr             <= ptr_next;
                        cnt             <= '0;
                        state           <= WAIT_BUSY;
                    end
                end

                WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        cnt   <= '0;
                        state <= WAIT_DONE;
                    end else if (cnt == CNT_LAST) begin
                        // Transmitter never answered; give up on this byte.
                        // ptr already moved past the owner at issue time.
                        cnt           <= '0;
                        err_timeout_q <= 1'b1;
                        grant_q       <= '0;
                        state         <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        grant_q <= '0;
                        state   <= IDLE;
                    end
                end

                default: begin
                    cnt     <= '0;
                    grant_q <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant         = grant_q;
    assign bus.req_ack       = req_ack_q;
    assign bus.tx_data       = tx_data_q;
    assign bus.tx_data_ready = tx_data_ready_q;
    assign bus.err_timeout   = err_timeout_q;
    assign bus.state_dbg     = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Bench for uart_tx_arbiter: a transmitter model answering tx_data_ready,
//   a transaction-level reference model checked every cycle, a vector table
//   of single-request grants, directed corner sequences and random traffic.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N), .BITLEN(W)) bus ();

    uart_tx_arbiter #(.NUM_REQ(N), .BITLEN(W), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- transmitter model controls ----------------
    int tx_len     = 3;
    int tx_left    = 0;
    bit tx_stuck   = 1'b0;
    bit busy_force = 1'b0;

    // ---------------- reference model state ----------------
    int          m_owner    = -1;
    int          m_ptr      = 0;
    int          m_since    = 0;
    bit          m_got_busy = 1'b0;
    bit          m_live     = 1'b0;
    bit          m_ready    = 1'b0;
    bit          m_err      = 1'b0;
    logic [N-1:0] m_ack     = '0;
    logic [W-1:0] m_data    = '0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the reference model, using the inputs that were
    // present at that edge.
    task automatic model_edge(input logic [N-1:0] pv, input logic pb,
                              input logic [N*W-1:0] pd, input logic pr);
        m_ready = 1'b0;
        m_err   = 1'b0;
        m_ack   = '0;
        if (pr) begin
            m_owner = -1;
            m_ptr   = 0;
            m_data  = '0;
            m_live  = 1'b1;
            exp_q.delete();
        end else if (!m_live) begin
            m_owner = -1;
        end else if (m_owner < 0) begin
            if (pv != '0 && pb == 1'b0) begin
                int pick;
                pick = -1;
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (pick < 0 && ((pv >> c) & N'(1)) != '0) pick = c;
                end
                m_owner    = pick;
                m_ptr      = (pick + 1) % N;
                m_data     = W'(pd >> (pick * W));
                m_ready    = 1'b1;
                m_ack      = N'(1) << pick;
                m_since    = 0;
                m_got_busy = 1'b0;
                exp_q.push_back(m_data);
            end
        end else if (!m_got_busy) begin
            if (pb) begin
                m_got_busy = 1'b1;
            end else begin
                m_since++;
                if (m_since == TO) begin
                    m_owner = -1;
                    m_err   = 1'b1;
                end
            end
        end else if (!pb) begin
            m_owner = -1;
        end
    endtask

    // Advance one cycle: edge, transmitter response, model update, checks.
    task automatic cycle();
        logic [N-1:0]   pv;
        logic           pb;
        logic [N*W-1:0] pd;
        logic           pr;
        logic           pready;
        pv     = bus.req_valid;
        pb     = bus.tx_busy;
        pd     = bus.req_data;
        pr     = rst;
        pready = bus.tx_data_ready;
        @(posedge clk);
        #1;
        if (pready === 1'b1 && !tx_stuck) tx_left = tx_len;
        bus.tx_busy = busy_force || (tx_left > 0);
        if (tx_left > 0) tx_left--;
        model_edge(pv, pb, pd, pr);
        if (m_live) begin
            logic [N-1:0] eg;
            eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
            check("grant",         32'(bus.grant),         32'(eg));
            check("req_ack",       32'(bus.req_ack),       32'(m_ack));
            check("tx_data_ready", 32'(bus.tx_data_ready), 32'(m_ready));
            check("err_timeout",   32'(bus.err_timeout),   32'(m_err));
            check("tx_data",       32'(bus.tx_data),       32'(m_data));
            if (bus.tx_data_ready === 1'b1) begin
                check("sb_queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check("sb_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst           = 1'b1;
        bus.req_valid = '0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic wait_ready(input string tag, output int waited);
        waited = 0;
        do begin
            cycle();
            waited++;
        end while (bus.tx_data_ready !== 1'b1 && waited < 64);
        check({tag, "_ready_seen"}, 32'(bus.tx_data_ready), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus.grant !== '0 || bus.tx_busy !== 1'b0 || tx_left > 0) && n < 80) begin
            cycle();
            n++;
        end
        check("idle_reached", 32'(bus.grant), 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] exp_grant;
        logic [W-1:0] exp_byte;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int waited;
        int cnt;
        int ack_cnt[N];

        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.tx_busy   = 1'b0;

        // Reset state
        do_reset();
        check("rst_grant",   32'(bus.grant),         32'd0);
        check("rst_ack",     32'(bus.req_ack),       32'd0);
        check("rst_ready",   32'(bus.tx_data_ready), 32'd0);
        check("rst_err",     32'(bus.err_timeout),   32'd0);
        check("rst_tx_data", 32'(bus.tx_data),       32'd0);

        // Single-request grants; pointer starts at 0 after reset.
        vecs[0] = '{4'b0001, 4'b0001, 8'h55};
        vecs[1] = '{4'b1111, 4'b0010, 8'hA1};
        vecs[2] = '{4'b0001, 4'b0001, 8'h55};
        vecs[3] = '{4'b1000, 4'b1000, 8'hA3};
        vecs[4] = '{4'b1001, 4'b0001, 8'h55};
        vecs[5] = '{4'b1001, 4'b1000, 8'hA3};
        vecs[6] = '{4'b0110, 4'b0010, 8'hA1};
        vecs[7] = '{4'b0110, 4'b0100, 8'hA2};
        vecs[8] = '{4'b0101, 4'b0001, 8'h55};
        vecs[9] = '{4'b1100, 4'b0100, 8'hA2};
        bus.req_data = {8'hA3, 8'hA2, 8'hA1, 8'h55};
        tx_len = 3;
        for (int i = 0; i < 10; i++) begin
            bus.req_valid = vecs[i].valid;
            wait_ready("vec", waited);
            check("vec_latency", 32'(waited),       32'd1);
            check("vec_grant",   32'(bus.grant),    32'(vecs[i].exp_grant));
            check("vec_ack",     32'(bus.req_ack),  32'(vecs[i].exp_grant));
            check("vec_data",    32'(bus.tx_data),  32'(vecs[i].exp_byte));
            bus.req_valid = '0;
            wait_idle();
        end

        // Continuous full request: order A0,A1,A2,A3,A0, one ack per lane per round.
        do_reset();
        bus.req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        bus.req_valid = 4'b1111;
        for (int b = 0; b < N; b++) ack_cnt[b] = 0;
        for (int k = 0; k < 5; k++) begin
            logic [W-1:0] e;
            e = 8'hA0 + W'(k % 4);
            wait_ready("rr", waited);
            check("rr_byte", 32'(bus.tx_data), 32'(e));
            if (k < 4) begin
                for (int b = 0; b < N; b++) ack_cnt[b] += int'(bus.req_ack[b]);
            end
        end
        for (int b = 0; b < N; b++) check("rr_ack_once", 32'(ack_cnt[b]), 32'd1);
        bus.req_valid = '0;
        wait_idle();

        // Fairness wrap: serve 3, then valid=1001 gives 0 then 3.
        do_reset();
        bus.req_valid = 4'b1000;
        wait_ready("wrap3", waited);
        check("wrap_first3", 32'(bus.grant), 32'b1000);
        bus.req_valid = '0;
        wait_idle();
        bus.req_valid = 4'b1001;
        wait_ready("wrap0", waited);
        check("wrap_then0", 32'(bus.grant), 32'b0001);
        wait_ready("wrap3b", waited);
        check("wrap_then3", 32'(bus.grant), 32'b1000);
        bus.req_valid = '0;
        wait_idle();

        // Busy never rises: timeout 16 cycles after the start pulse.
        tx_stuck = 1'b1;
        bus.req_valid = 4'b0001;
        wait_ready("to", waited);
        bus.req_valid = '0;
        cnt = 0;
        do begin
            cycle();
            cnt++;
        end while (bus.err_timeout !== 1'b1 && cnt < 40);
        check("to_latency", 32'(cnt),       32'd16);
        check("to_grant",   32'(bus.grant), 32'd0);
        tx_stuck = 1'b0;
        bus.req_valid = 4'b0011;
        wait_ready("to_after", waited);
        check("to_ptr_advanced", 32'(bus.grant), 32'b0010);
        bus.req_valid = '0;
        wait_idle();

        // Transmitter busy while idle: nothing issues until it drops.
        busy_force = 1'b1;
        cycle();
        bus.req_valid = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("busy_hold_grant", 32'(bus.grant), 32'd0);
        end
        busy_force = 1'b0;
        cycle();
        check("busy_drop_grant", 32'(bus.grant), 32'd0);
        cycle();
        check("busy_release_grant", 32'(bus.grant), 32'b0010);
        bus.req_valid = '0;
        wait_idle();

        // Reset during WAIT_DONE, then valid=0110 grants requester 1.
        do_reset();
        tx_len = 6;
        bus.req_valid = 4'b0001;
        wait_ready("mid", waited);
        bus.req_valid = '0;
        cnt = 0;
        while (bus.tx_busy !== 1'b1 && cnt < 10) begin
            cycle();
            cnt++;
        end
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mid_rst_grant", 32'(bus.grant),         32'd0);
        check("mid_rst_ack",   32'(bus.req_ack),       32'd0);
        check("mid_rst_ready", 32'(bus.tx_data_ready), 32'd0);
        check("mid_rst_err",   32'(bus.err_timeout),   32'd0);
        check("mid_rst_data",  32'(bus.tx_data),       32'd0);
        bus.req_valid = 4'b0110;
        wait_ready("mid_after", waited);
        check("mid_first_grant", 32'(bus.grant), 32'b0010);
        bus.req_valid = '0;
        wait_idle();

        // Random traffic against the reference model.
        for (int i = 0; i < 1500; i++) begin
            bus.req_valid = N'($urandom_range(0, (1 << N) - 1));
            for (int b = 0; b < N; b++) bus.req_data[b*W +: W] = W'($urandom_range(0, 255));
            busy_force = ($urandom_range(0, 7) == 0);
            tx_stuck   = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 15) == 0) tx_len = int'($urandom_range(1, 5));
            rst = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst           = 1'b0;
        busy_force    = 1'b0;
        tx_stuck      = 1'b0;
        bus.req_valid = '0;
        cycle();
        wait_idle();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
